// File: rtl/i2cmb_seq.sv
// i2cmb_seq -- request sequencer for an i2cmb-style I2C master controller.
//
// Turns a simple read/write request (bus, slave address, byte count) into the
// Wishbone register accesses the controller expects: select bus, Start, address
// byte, data bytes, Stop. Each controller command is a "command step": write
// CMDR, wait for a fresh irq_i, read CMDR back for status.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid/req_ready          request handshake; req_rw/bus/addr/len latched on accept
//   wdata_valid/wdata_ready/wdata  write byte stream (ready pulses once per byte)
//   rdata_valid/rdata            one-cycle strobe per read byte
//   done/err/busy                end-of-transaction pulse, status (00 ok, 01 NAK,
//                                10 arbitration lost, 11 bad length), in-progress flag
//   cyc_o/stb_o/we_o/adr_o/dat_o/dat_i/ack_i  Wishbone master
//   irq_i                        controller interrupt
module i2cmb_seq #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int NUM_I2C_BUSSES = 1,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int MAX_LEN        = 16,
  localparam int BUS_W = $clog2(NUM_I2C_BUSSES) + 1,
  localparam int LEN_W = $clog2(MAX_LEN) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_rw,
  input  logic [BUS_W-1:0]          req_bus,
  input  logic [I2C_ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_W-1:0]          req_len,
  input  logic                      wdata_valid,
  output logic                      wdata_ready,
  input  logic [7:0]                wdata,
  output logic                      rdata_valid,
  output logic [7:0]                rdata,
  output logic                      done,
  output logic [1:0]                err,
  output logic                      busy,
  output logic                      cyc_o,
  output logic                      stb_o,
  output logic                      we_o,
  output logic [WB_ADDR_WIDTH-1:0]  adr_o,
  output logic [WB_DATA_WIDTH-1:0]  dat_o,
  input  logic [WB_DATA_WIDTH-1:0]  dat_i,
  input  logic                      ack_i,
  input  logic                      irq_i
);

  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_SETBUS, S_START, S_ADDR, S_DATA, S_STOP, S_FIN
  } state_t;

  // Position inside the current state's sequence of bus accesses.
  typedef enum logic [2:0] {
    P_DPRW, P_CMDW, P_IRQ, P_CMDR, P_DPRR, P_WDAT
  } phase_t;

  state_t                    r_state;
  phase_t                    r_phase;
  logic                      r_rw;
  logic [BUS_W-1:0]          r_bus;
  logic [I2C_ADDR_WIDTH-1:0] r_addr;
  logic [LEN_W-1:0]          r_len;
  logic [LEN_W-1:0]          r_cnt;
  logic [7:0]                r_wbyte;
  logic                      r_irq_low;

  logic                      w_last;
  logic [2:0]                w_op;
  logic                      w_bus_req;
  logic                      w_we;
  logic [WB_ADDR_WIDTH-1:0]  w_adr;
  logic [WB_DATA_WIDTH-1:0]  w_dat;
  logic                      w_ack;
  logic                      w_bad_len;

  assign w_ack     = cyc_o & ack_i;
  assign w_bad_len = (req_len == '0) || (req_len > LEN_W'(MAX_LEN));

  // What the current state/phase wants on the bus, and which command it issues.
  always_comb begin
    w_last    = (r_cnt == r_len - LEN_W'(1));
    w_op      = 3'b000;
    w_bus_req = 1'b0;
    w_we      = 1'b0;
    w_adr     = ADR_CMDR;
    w_dat     = '0;
    case (r_state)
      S_SETBUS: w_op = 3'b110;
      S_START:  w_op = 3'b100;
      S_ADDR:   w_op = 3'b001;
      S_DATA:   w_op = r_rw ? (w_last ? 3'b011 : 3'b010) : 3'b001;
      S_STOP:   w_op = 3'b101;
      default:  w_op = 3'b000;
    endcase
    if (r_state == S_INIT) begin
      w_bus_req = 1'b1;
      w_we      = 1'b1;
      w_adr     = ADR_CSR;
      w_dat     = WB_DATA_WIDTH'(8'hC0);
    end else if (r_state != S_IDLE && r_state != S_FIN) begin
      case (r_phase)
        P_DPRW: begin
          w_bus_req = 1'b1;
          w_we      = 1'b1;
          w_adr     = ADR_DPR;
          case (r_state)
            S_SETBUS: w_dat = WB_DATA_WIDTH'(r_bus);
            S_ADDR:   w_dat = WB_DATA_WIDTH'({r_addr, r_rw});
            default:  w_dat = WB_DATA_WIDTH'(r_wbyte);
          endcase
        end
        P_CMDW: begin
          w_bus_req = 1'b1;
          w_we      = 1'b1;
          w_adr     = ADR_CMDR;
          w_dat     = WB_DATA_WIDTH'(w_op);
        end
        P_CMDR: begin
          w_bus_req = 1'b1;
          w_adr     = ADR_CMDR;
        end
        P_DPRR: begin
          w_bus_req = 1'b1;
          w_adr     = ADR_DPR;
        end
        default: w_bus_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_INIT;
      r_phase     <= P_DPRW;
      r_rw        <= 1'b0;
      r_bus       <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_wbyte     <= '0;
      r_irq_low   <= 1'b0;
      req_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      done        <= 1'b0;
      err         <= '0;
      busy        <= 1'b0;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      we_o        <= 1'b0;
      adr_o       <= '0;
      dat_o       <= '0;
    end else begin
      done        <= 1'b0;
      rdata_valid <= 1'b0;

      // A cycle launches only from cyc_o=0; since the phase advances on the
      // ack edge, the cycle after an ack is always idle before the next launch.
      if (w_bus_req && !cyc_o) begin
        cyc_o <= 1'b1;
        stb_o <= 1'b1;
        we_o  <= w_we;
        adr_o <= w_adr;
        dat_o <= w_dat;
      end else if (w_ack) begin
        cyc_o <= 1'b0;
        stb_o <= 1'b0;
        we_o  <= 1'b0;
      end

      case (r_state)
        S_INIT: begin
          if (w_ack) begin
            r_state   <= S_IDLE;
            req_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_rw      <= req_rw;
            r_bus     <= req_bus;
            r_addr    <= req_addr;
            r_len     <= req_len;
            r_cnt     <= '0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            if (w_bad_len) begin
              err     <= 2'b11;
              r_state <= S_FIN;
            end else begin
              err     <= 2'b00;
              r_state <= S_SETBUS;
              r_phase <= P_DPRW;
            end
          end
        end
        S_FIN: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          case (r_phase)
            P_DPRW: if (w_ack) r_phase <= P_CMDW;
            P_CMDW: begin
              if (w_ack) begin
                r_phase   <= P_IRQ;
                // An irq already high at the ack is stale: require it to drop first.
                r_irq_low <= ~irq_i;
              end
            end
            P_IRQ: begin
              if (!irq_i) r_irq_low <= 1'b1;
              else if (r_irq_low) r_phase <= P_CMDR;
            end
            P_CMDR: begin
              if (w_ack) begin
                if (dat_i[5]) begin
                  err     <= 2'b10;
                  r_state <= S_FIN;
                end else begin
                  case (r_state)
                    S_SETBUS: begin
                      r_state <= S_START;
                      r_phase <= P_CMDW;
                    end
                    S_START: begin
                      r_state <= S_ADDR;
                      r_phase <= P_DPRW;
                    end
                    S_ADDR: begin
                      if (dat_i[6]) begin
                        err     <= 2'b01;
                        r_state <= S_STOP;
                        r_phase <= P_CMDW;
                      end else begin
                        r_state <= S_DATA;
                        r_phase <= r_rw ? P_CMDW : P_WDAT;
                      end
                    end
                    S_DATA: begin
                      if (r_rw) begin
                        r_phase <= P_DPRR;
                      end else if (dat_i[6]) begin
                        err     <= 2'b01;
                        r_state <= S_STOP;
                        r_phase <= P_CMDW;
                      end else if (w_last) begin
                        r_state <= S_STOP;
                        r_phase <= P_CMDW;
                      end else begin
                        r_cnt   <= r_cnt + LEN_W'(1);
                        r_phase <= P_WDAT;
                      end
                    end
                    default: r_state <= S_FIN;
                  endcase
                end
              end
            end
            P_DPRR: begin
              if (w_ack) begin
                rdata       <= dat_i[7:0];
                rdata_valid <= 1'b1;
                r_phase     <= P_CMDW;
                if (w_last) r_state <= S_STOP;
                else        r_cnt   <= r_cnt + LEN_W'(1);
              end
            end
            P_WDAT: begin
              if (wdata_ready) begin
                wdata_ready <= 1'b0;
                r_wbyte     <= wdata;
                r_phase     <= P_DPRW;
              end else if (wdata_valid) begin
                wdata_ready <= 1'b1;
              end
            end
            default: r_phase <= P_DPRW;
          endcase
        end
      endcase
    end
  end

endmodule

// File: doc/i2cmb_seq.md
I2CMB_SEQ -- requirements
Module: i2cmb_seq

Interface
REQ-001 Parameters SHALL be:
  - WB_ADDR_WIDTH, default 2, Wishbone address width.
  - WB_DATA_WIDTH, default 8, Wishbone data width.
  - NUM_I2C_BUSSES, default 1, number of I2C busses selectable on the controller.
  - I2C_ADDR_WIDTH, default 7, I2C slave address width.
  - MAX_LEN, default 16, maximum number of bytes per transaction.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
  - clk_i  in  1  clock.
  - rst_i  in  1  synchronous active-high reset.
REQ-003 Request and status ports SHALL be:
  - req_valid  in  1  request offered.
  - req_ready  out  1  request accepted when high with req_valid.
  - req_rw  in  1  0 = write, 1 = read.
  - req_bus  in  $clog2(NUM_I2C_BUSSES)+1  bus ID.
  - req_addr  in  I2C_ADDR_WIDTH  slave address.
  - req_len  in  $clog2(MAX_LEN)+1  byte count, valid range 1..MAX_LEN.
  - wdata_valid  in  1  write byte offered.
  - wdata_ready  out  1  write byte consumed.
  - wdata  in  8  write byte.
  - rdata_valid  out  1  one-cycle read byte strobe.
  - rdata  out  8  read byte.
  - done  out  1  one-cycle transaction-end pulse.
  - err  out  2  end status, sampled with done: 00 ok, 01 NAK, 10 arbitration lost, 11 bad length.
  - busy  out  1  transaction in progress.
REQ-004 Wishbone master ports SHALL be:
  - cyc_o  out  1.
  - stb_o  out  1.
  - we_o  out  1.
  - adr_o  out  WB_ADDR_WIDTH.
  - dat_o  out  WB_DATA_WIDTH.
  - dat_i  in  WB_DATA_WIDTH.
  - ack_i  in  1.
  - irq_i  in  1  controller interrupt.

Function
REQ-005 Register map SHALL be CSR=0, DPR=1, CMDR=2, FSMR=3. CMDR opcodes: Write 001, ReadAck 010, ReadNak 011, Start 100, Stop 101, SetBus 110. Status bits read from CMDR: [7] DON, [6] NAK, [5] AL, [4] ERR.
REQ-006 Wishbone cycle:
  - Assert cyc_o/stb_o with stable we_o/adr_o/dat_o until the cycle where ack_i=1.
  - On the ack cycle, capture dat_i for reads.
  - Deassert cyc_o/stb_o the following cycle.
  - Keep at least one idle cycle between bus cycles.
REQ-007 Command step = write CMDR, wait for irq_i=1, read CMDR. An irq_i already high before the CMDR write ack SHALL be ignored.
REQ-008 Main FSM states: INIT, IDLE, SETBUS, START, ADDR, DATA, STOP, FIN.
REQ-009 INIT (entered after reset): write CSR=0xC0 once, then go to IDLE.
REQ-010 IDLE: req_ready=1. On req_valid, latch all req_* fields and set busy=1. If req_len=0 or req_len>MAX_LEN, go to FIN with err=11 and issue no bus cycles.
REQ-011 SETBUS: write DPR=req_bus, then perform a SetBus command step.
REQ-012 START: perform a Start command step.
REQ-013 ADDR: write DPR={req_addr,req_rw}, then perform a Write command step. If NAK=1, set err=01 and go to STOP.
REQ-014 DATA, write mode:
  - Per byte: wait for wdata_valid; assert wdata_ready for exactly 1 cycle to consume wdata.
  - Write DPR=wdata, then perform a Write command step.
  - If NAK=1, set err=01 and go to STOP, skipping the remaining bytes.
REQ-015 DATA, read mode:
  - Use ReadAck for bytes 1..len-1 and ReadNak for byte len.
  - After each command step, read DPR and pulse rdata_valid for 1 cycle with rdata=DPR.
REQ-016 In any state, a CMDR read with AL=1 SHALL set err=10 and go to FIN without issuing Stop.
REQ-017 STOP: perform a Stop command step, then go to FIN.
REQ-018 FIN: pulse done for 1 cycle, clear busy, go to IDLE. err SHALL hold until the next request is accepted.
REQ-019 Byte counter: counts 0..req_len-1; the last byte is detected when count==req_len-1. No wrap.
REQ-020 req_ready and wdata_ready SHALL both be 0 outside IDLE and outside DATA-write respectively.

Reset
REQ-021 rst_i=1 on any clock edge SHALL immediately:
  - drive all outputs to 0 (cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, wdata_ready, rdata_valid, rdata, done, err, busy);
  - clear the byte counter;
  - set the state to INIT.
REQ-022 Reset mid-transaction SHALL abandon the transaction with no done pulse. After reset release, the CSR enable write SHALL be reissued.

Verification
REQ-023 Reset release -> first bus cycle is CSR write of 0xC0; req_ready rises only after its ack.
REQ-024 Write request, bus 0, addr 0x22, len 3, data 0x11/0x22/0x33 -> Wishbone write sequence:
  - DPR 0x00, CMDR 0x06, CMDR 0x04, DPR 0x44, CMDR 0x01;
  - DPR 0x11, CMDR 0x01, DPR 0x22, CMDR 0x01, DPR 0x33, CMDR 0x01;
  - CMDR 0x05;
  - then done with err=00.
REQ-025 Read request, addr 0x22, len 2, slave returns 0xA5, 0x5A -> DPR 0x45; CMDR 0x02 then 0x03; rdata_valid pulses with 0xA5 then 0x5A; done with err=00.
REQ-026 Address NAK (CMDR reads 0x40 after the ADDR step) -> no data bytes, Stop issued, done with err=01, wdata_ready never asserted.
REQ-027 req_len=0 -> done within 2 cycles with err=11 and no cyc_o assertion; an AL=1 CMDR read during START -> done with err=10 and no Stop.
REQ-028 rst_i asserted mid-DATA -> cyc_o=0 next cycle, no done pulse; CSR 0xC0 reissued after release.
